// File: rtl/next_link_pkg.sv
// next_link_pkg: constants and types shared by the NeXT serial link sender and
// receiver.
//   PKT_W_DEF     payload width of one link packet
//   MIN_GAP_DEF   default number of idle-0 bits required after a packet
//   AUDIO_REQ_PKT packet the sender emits to request audio
//   rx_state_t    receiver FSM states
package next_link_pkg;

    localparam int unsigned PKT_W_DEF   = 40;
    localparam int unsigned MIN_GAP_DEF = 3;

    localparam logic [PKT_W_DEF-1:0] AUDIO_REQ_PKT = 40'h07_0000_0000;

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        GAP
    } rx_state_t;

endpackage

// File: rtl/sync_ff2.sv
// sync_ff2: SYNC_STG-deep single-bit synchronizer.
// Ports:
//   clk    in   destination clock
//   rst_n  in   asynchronous active-low reset (all stages cleared to 0)
//   d      in   asynchronous input
//   q      out  synchronized output, SYNC_STG clk edges behind d
module sync_ff2 #(
    parameter int unsigned SYNC_STG = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [SYNC_STG-1:0] stg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stg <= '0;
        end else begin
            stg <= {stg[SYNC_STG-2:0], d};
        end
    end

    assign q = stg[SYNC_STG-1];

endmodule

// File: rtl/next_packet_receiver.sv
// next_packet_receiver: deserializer for the NeXT-side serial link.
// A frame is a start bit (1), PKT_W data bits MSB first, then at least MIN_GAP
// idle zeros. Good frames land in a one-entry valid/ready holding register.
// Optional statistics counters are built when the macro RX_STATS_EN is defined;
// otherwise pkt_count and err_count are tied to 0.
// Ports:
//   clk          in   system clock, one serial bit per rising edge
//   rst_n        in   asynchronous active-low reset
//   sin          in   serial input (synchronized internally)
//   out_data     out  received payload, stable while out_valid=1
//   out_valid    out  payload available
//   out_ready    in   consumer accepts when out_valid & out_ready
//   frame_error  out  one-cycle pulse: 1 seen during the gap, frame discarded
//   overrun      out  one-cycle pulse: commit lost because holding was full
//   busy         out  FSM in RECV or GAP
//   pkt_count    out  good frames committed (saturating, RX_STATS_EN)
//   err_count    out  frame_error + overrun events (saturating, RX_STATS_EN)
module next_packet_receiver
    import next_link_pkg::*;
#(
    parameter int unsigned PKT_W    = PKT_W_DEF,
    parameter int unsigned MIN_GAP  = MIN_GAP_DEF,
    parameter int unsigned SYNC_STG = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sin,
    output logic [PKT_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             frame_error,
    output logic             overrun,
    output logic             busy,
    output logic [15:0]      pkt_count,
    output logic [15:0]      err_count
);

    localparam int unsigned BC_W = $clog2(PKT_W + 1);
    localparam int unsigned GC_W = $clog2(MIN_GAP + 1);

    logic             sin_s;
    rx_state_t        state, state_nx;
    logic [PKT_W-1:0] shreg, shreg_nx;
    logic [BC_W-1:0]  bit_cnt, bit_cnt_nx;
    logic [GC_W-1:0]  gap_cnt, gap_cnt_nx;
    logic             discard, discard_nx;
    logic             commit;
    logic             fe_nx;
    logic             ov_nx;
    logic             load;

    sync_ff2 #(.SYNC_STG(SYNC_STG)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (sin),
        .q     (sin_s)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            gap_cnt <= '0;
            discard <= 1'b0;
        end else begin
            state   <= state_nx;
            shreg   <= shreg_nx;
            bit_cnt <= bit_cnt_nx;
            gap_cnt <= gap_cnt_nx;
            discard <= discard_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        shreg_nx   = shreg;
        bit_cnt_nx = bit_cnt;
        gap_cnt_nx = gap_cnt;
        discard_nx = discard;
        commit     = 1'b0;
        fe_nx      = 1'b0;
        case (state)
            IDLE: begin
                if (sin_s) begin
                    state_nx   = RECV;
                    bit_cnt_nx = '0;
                end
            end
            RECV: begin
                shreg_nx   = {shreg[PKT_W-2:0], sin_s};
                bit_cnt_nx = bit_cnt + 1'b1;
                if (bit_cnt == BC_W'(PKT_W - 1)) begin
                    state_nx   = GAP;
                    gap_cnt_nx = '0;
                    discard_nx = 1'b0;
                end
            end
            GAP: begin
                if (sin_s) begin
                    // Only the first violation of a frame pulses, so a long
                    // run of ones never stretches frame_error.
                    fe_nx      = ~discard;
                    discard_nx = 1'b1;
                    gap_cnt_nx = '0;
                end else if (gap_cnt == GC_W'(MIN_GAP - 1)) begin
                    // This zero is the MIN_GAP-th in a row.
                    state_nx   = IDLE;
                    gap_cnt_nx = '0;
                    commit     = ~discard;
                end else begin
                    gap_cnt_nx = gap_cnt + 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign ov_nx = commit & out_valid & ~out_ready;
    assign load  = commit & ~ov_nx;
    assign busy  = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data    <= '0;
            out_valid   <= 1'b0;
            frame_error <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            frame_error <= fe_nx;
            overrun     <= ov_nx;
            if (load) begin
                out_data  <= shreg;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef RX_STATS_EN
    logic [15:0] pkt_cnt_q, err_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_cnt_q <= '0;
            err_cnt_q <= '0;
        end else begin
            if (load && pkt_cnt_q != '1) begin
                pkt_cnt_q <= pkt_cnt_q + 1'b1;
            end
            if ((fe_nx || ov_nx) && err_cnt_q != '1) begin
                err_cnt_q <= err_cnt_q + 1'b1;
            end
        end
    end

    assign pkt_count = pkt_cnt_q;
    assign err_count = err_cnt_q;
`else
    assign pkt_count = '0;
    assign err_count = '0;
`endif

endmodule

// File: tb/tb_next_packet_receiver.sv
// Scoreboard bench for next_packet_receiver. A reference model parses the
// serial stream as the spec describes it (2-cycle input delay, frame = start +
// PKT_W bits + MIN_GAP consecutive zeros) and pushes every payload that should
// be loaded into a queue; a monitor pops on each DUT transfer and compares.
module tb_next_packet_receiver;
    import next_link_pkg::*;

    localparam int unsigned W   = PKT_W_DEF;
    localparam int unsigned GAP = MIN_GAP_DEF;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         sin = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_data;
    logic         out_valid, frame_error, overrun, busy;
    logic [15:0]  pkt_count, err_count;

    next_packet_receiver #(.PKT_W(W), .MIN_GAP(GAP), .SYNC_STG(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sin         (sin),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .frame_error (frame_error),
        .overrun     (overrun),
        .busy        (busy),
        .pkt_count   (pkt_count),
        .err_count   (err_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int delivered = 0;
    int fe_seen = 0;
    int ov_seen = 0;
    int ready_mode = 0;   // 0: ready low, 1: ready high, 2: random, 3: manual

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic         d1 = 1'b0, d2 = 1'b0, b;
    bit           active = 0, discarded = 0;
    int           nbits = 0, zeros = 0;
    logic [W-1:0] acc = '0;
    bit           m_valid = 0, m_fe = 0, m_ov = 0, commit;
    int           m_loads = 0;
    logic [15:0]  exp_pkt = '0, exp_err = '0;
    logic [W-1:0] sb[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d1 = 0; d2 = 0; active = 0; discarded = 0; nbits = 0; zeros = 0;
            acc = '0; m_valid = 0; m_fe = 0; m_ov = 0;
            exp_pkt = '0; exp_err = '0;
            sb.delete();
        end else begin
            b = d2; d2 = d1; d1 = sin;
            m_fe = 0; m_ov = 0; commit = 0;
            if (!active) begin
                if (b) begin
                    active = 1; nbits = 0; acc = '0; zeros = 0; discarded = 0;
                end
            end else if (nbits < int'(W)) begin
                acc = {acc[W-2:0], b};
                nbits++;
            end else if (b) begin
                m_fe = !discarded;
                discarded = 1;
                zeros = 0;
            end else begin
                zeros++;
                if (zeros == int'(GAP)) begin
                    active = 0;
                    commit = !discarded;
                end
            end
            if (commit) begin
                if (m_valid && !out_ready) begin
                    m_ov = 1;
                end else begin
                    sb.push_back(acc);
                    m_valid = 1;
                    m_loads++;
                end
            end else if (m_valid && out_ready) begin
                m_valid = 0;
            end
`ifdef RX_STATS_EN
            if (commit && !m_ov && exp_pkt != 16'hFFFF) exp_pkt = exp_pkt + 1;
            if ((m_fe || m_ov) && exp_err != 16'hFFFF) exp_err = exp_err + 1;
`endif
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [W-1:0] exp_d;
        check("out_valid", out_valid, m_valid);
        check("frame_error", frame_error, m_fe);
        check("overrun", overrun, m_ov);
        check("busy", busy, active);
        check("pkt_count", pkt_count, exp_pkt);
        check("err_count", err_count, exp_err);
        if (frame_error) fe_seen++;
        if (overrun) ov_seen++;
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                total++; bad++;
                $display("FAIL out_data: transfer of %0h with nothing expected at %0t", out_data, $time);
            end else begin
                exp_d = sb.pop_front();
                check("out_data", out_data, exp_d);
                delivered++;
            end
        end
    end

    // ---------------- drivers ----------------
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0: out_ready = 1'b0;
            1: out_ready = 1'b1;
            2: out_ready = 1'($urandom_range(0, 1));
            default: ;
        endcase
    end

    task automatic drive(input logic v);
        @(posedge clk);
        #1 sin = v;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0);
    endtask

    // err_at: 1-based gap cycle that carries a 1 (0 = clean gap)
    task automatic send_frame(input logic [W-1:0] data, input int gap, input int err_at);
        drive(1'b1);
        for (int i = int'(W) - 1; i >= 0; i--) drive(data[i]);
        for (int g = 1; g <= gap; g++) drive(g == err_at);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, f0, o0, gap, err_at;
        logic [W-1:0] rnd;

        // T1: reset held while sin toggles
        ready_mode = 1;
        for (int i = 0; i < 8; i++) drive(1'($urandom_range(0, 1)));
        check("t1_out_data", out_data, '0);
        check("t1_busy", busy, 1'b0);
        @(posedge clk); #1 rst_n = 1'b1; sin = 1'b0;
        idle(10);
        check("t1_no_activity", delivered, 0);

        // T2: single frame
        d0 = delivered;
        send_frame(AUDIO_REQ_PKT, GAP, 0);
        idle(8);
        check("t2_delivered", delivered - d0, 1);

        // T3: back-to-back with consumer stalled -> overrun
        ready_mode = 0;
        d0 = delivered; o0 = ov_seen;
        send_frame(40'hD999999991, GAP, 0);
        send_frame(40'hD999999993, GAP, 0);
        idle(6);
        check("t3_held", delivered - d0, 0);
        check("t3_overrun", ov_seen - o0, 1);
        ready_mode = 1;
        idle(4);
        check("t3_delivered", delivered - d0, 1);

        // T4: gap violation on 2nd gap cycle, then a clean frame
        d0 = delivered; f0 = fe_seen;
        send_frame(40'h12_3456_789A, 2 + GAP, 2);
        send_frame(40'hA5_5A5A_A5A5, GAP, 0);
        idle(8);
        check("t4_frame_error", fe_seen - f0, 1);
        check("t4_delivered", delivered - d0, 1);

        // T5: reset after 20 data bits
        d0 = delivered;
        drive(1'b1);
        for (int i = 0; i < 20; i++) drive(1'($urandom_range(0, 1)));
        @(posedge clk); #1 rst_n = 1'b0; sin = 1'b0;
        idle(3);
        check("t5_busy", busy, 1'b0);
        check("t5_no_commit", delivered - d0, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        idle(4);
        send_frame(40'hFE_DCBA_9876, GAP, 0);
        idle(8);
        check("t5_delivered", delivered - d0, 1);

        // T6: commit in the same cycle as a transfer
        ready_mode = 3;
        out_ready = 1'b0;
        d0 = delivered; o0 = ov_seen;
        send_frame(40'h11_2233_4455, GAP, 0);
        send_frame(40'h66_7788_99AA, 0, 0);
        for (int i = 1; i <= 5; i++) begin
            drive(1'b0);
            out_ready = (i == 5);
        end
        drive(1'b0);
        out_ready = 1'b0;
        check("t6_valid_kept", out_valid, 1'b1);
        check("t6_no_overrun", ov_seen - o0, 0);
        check("t6_first_out", delivered - d0, 1);
        ready_mode = 1;
        idle(3);
        check("t6_delivered", delivered - d0, 2);

        // Randomized frames, gaps, violations and consumer stalls
        ready_mode = 2;
        for (int n = 0; n < 40; n++) begin
            rnd = {8'($urandom), 32'($urandom)};
            err_at = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, GAP)) : 0;
            gap = int'(GAP) + int'($urandom_range(0, 3));
            if (err_at != 0) gap = gap + err_at;
            send_frame(rnd, gap, err_at);
        end
        ready_mode = 1;
        idle(12);
        check("rand_drained", sb.size(), 0);
        check("rand_loads", delivered, m_loads);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
